// File: rtl/stack_unit_pkg.sv
// Shared sizing, Delta encoding and small decode helpers for the hardware LIFO stack.
package stack_unit_pkg;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int PW    = 5;
    localparam int AW    = PW - 1;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [PW-1:0]    ptr_t;
    typedef logic [AW-1:0]    addr_t;

    typedef struct packed {
        logic push;
        logic pop;
        logic is_call;
    } op_t;

    // Call only matters on a push; a pop with Call set is an ordinary pop.
    function automatic op_t decode_op(input logic pop_push, input logic delta, input logic call);
        op_t op;
        op.push    = pop_push && (delta == OP_PUSH);
        op.pop     = pop_push && (delta == OP_POP);
        op.is_call = op.push && call;
        return op;
    endfunction

    function automatic addr_t slot_below(input ptr_t sp, input ptr_t off);
        return addr_t'(sp - off - ptr_t'(1));
    endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Control-side bus of the stack: op strobes and operands in, pop/peek data and status out.
interface stack_unit_if;
    import stack_unit_pkg::*;

    logic       pop_push;
    logic       delta;
    logic       call;
    word_t      data_in;
    word_t      pc_in;
    logic [3:0] peek_off;
    logic       clear_err;

    word_t      top_out;
    logic       pop_valid;
    word_t      peek_data;
    ptr_t       sp;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    modport master (
        output pop_push, delta, call, data_in, pc_in, peek_off, clear_err,
        input  top_out, pop_valid, peek_data, sp, empty, full, overflow, underflow
    );

    modport slave (
        input  pop_push, delta, call, data_in, pc_in, peek_off, clear_err,
        output top_out, pop_valid, peek_data, sp, empty, full, overflow, underflow
    );

endinterface

// File: rtl/stack_unit_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, async top and peek read ports.
module stack_ram
    import stack_unit_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t waddr,
    input  word_t wdata,
    input  addr_t top_addr,
    output word_t top_data,
    input  addr_t peek_addr,
    output word_t peek_data
);

    word_t mem_q [DEPTH];

    // Contents are deliberately left unreset; SP decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign top_data  = mem_q[top_addr];
    assign peek_data = mem_q[peek_addr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack beside the register file: pointer, sticky error flags and registered pop result.
module stack_unit
    import stack_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    stack_unit_if.slave  bus
);

    localparam ptr_t SP_FULL = ptr_t'(DEPTH);

    ptr_t  sp_q, sp_d;
    word_t top_out_q, top_out_d;
    logic  pop_valid_q, pop_valid_d;
    logic  overflow_q, overflow_d;
    logic  underflow_q, underflow_d;

    op_t   op;
    logic  empty, full;
    logic  push_ok, pop_ok;
    word_t wr_data;
    word_t ram_top, ram_peek;
    addr_t top_addr, peek_addr;
    ptr_t  peek_off_ext;
    logic  peek_hit;

    stack_ram u_ram (
        .clk       (clk),
        .we        (push_ok),
        .waddr     (sp_q[AW-1:0]),
        .wdata     (wr_data),
        .top_addr  (top_addr),
        .top_data  (ram_top),
        .peek_addr (peek_addr),
        .peek_data (ram_peek)
    );

    always_comb begin
        op           = decode_op(bus.pop_push, bus.delta, bus.call);
        empty        = (sp_q == '0);
        full         = (sp_q == SP_FULL);
        push_ok      = op.push && !full;
        pop_ok       = op.pop && !empty;
        wr_data      = op.is_call ? bus.pc_in : bus.data_in;
        top_addr     = slot_below(sp_q, '0);
        peek_off_ext = ptr_t'(bus.peek_off);
        peek_addr    = slot_below(sp_q, peek_off_ext);
        peek_hit     = (peek_off_ext < sp_q);
    end

    // A fresh error on the same edge as ClearErr must win, so the set terms come last.
    always_comb begin
        sp_d        = sp_q;
        top_out_d   = top_out_q;
        pop_valid_d = 1'b0;
        overflow_d  = bus.clear_err ? 1'b0 : overflow_q;
        underflow_d = bus.clear_err ? 1'b0 : underflow_q;

        if (push_ok) begin
            sp_d = sp_q + ptr_t'(1);
        end
        if (pop_ok) begin
            sp_d        = sp_q - ptr_t'(1);
            top_out_d   = ram_top;
            pop_valid_d = 1'b1;
        end
        if (op.push && full) begin
            overflow_d = 1'b1;
        end
        if (op.pop && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q        <= '0;
            top_out_q   <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            top_out_q   <= top_out_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.top_out   = top_out_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.peek_data = peek_hit ? ram_peek : '0;
    assign bus.sp        = sp_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with hand-computed expectations for each scenario.
module tb_stack_unit;
    import stack_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   errorCount = 0;

    stack_unit_if sif();

    stack_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Holds the op for exactly one rising edge, then returns to idle at edge+1ns.
    task automatic applyStimulus(input logic popPush, input logic delta, input logic call,
                                 input logic [15:0] dataIn, input logic [15:0] pcIn,
                                 input logic clearErr);
        sif.pop_push  = popPush;
        sif.delta     = delta;
        sif.call      = call;
        sif.data_in   = dataIn;
        sif.pc_in     = pcIn;
        sif.clear_err = clearErr;
        @(posedge clk);
        #1;
        sif.pop_push  = 1'b0;
        sif.delta     = 1'b0;
        sif.call      = 1'b0;
        sif.data_in   = '0;
        sif.pc_in     = '0;
        sif.clear_err = 1'b0;
    endtask

    task automatic pushWord(input logic [15:0] d);
        applyStimulus(1'b1, 1'b0, 1'b0, d, 16'h0000, 1'b0);
    endtask

    task automatic popWord();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    initial begin
        logic [15:0] peekExp [6];

        sif.pop_push  = 1'b0;
        sif.delta     = 1'b0;
        sif.call      = 1'b0;
        sif.data_in   = '0;
        sif.pc_in     = '0;
        sif.peek_off  = '0;
        sif.clear_err = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");
        checkOutput("reset_sp", sif.sp, 0);
        checkOutput("reset_empty", sif.empty, 1);
        checkOutput("reset_full", sif.full, 0);

        // Scenario 1: build up non-reset state, then assert reset between edges
        popWord();
        checkOutput("s1_underflow_set", sif.underflow, 1);
        for (int i = 1; i <= 4; i++) pushWord(16'(i));
        popWord();
        checkOutput("s1_pre_sp", sif.sp, 3);
        checkOutput("s1_pre_top", sif.top_out, 16'h0004);
        checkOutput("s1_pre_valid", sif.pop_valid, 1);
        rst = 1'b1;
        #2;
        checkOutput("s1_rst_sp", sif.sp, 0);
        checkOutput("s1_rst_empty", sif.empty, 1);
        checkOutput("s1_rst_top", sif.top_out, 0);
        checkOutput("s1_rst_valid", sif.pop_valid, 0);
        checkOutput("s1_rst_underflow", sif.underflow, 0);
        checkOutput("s1_rst_overflow", sif.overflow, 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Scenario 2: LIFO order, pop directly after push
        pushWord(16'h0005);
        pushWord(16'h1234);
        pushWord(16'hBEEF);
        popWord();
        checkOutput("s2_pop0_top", sif.top_out, 16'hBEEF);
        checkOutput("s2_pop0_valid", sif.pop_valid, 1);
        popWord();
        checkOutput("s2_pop1_top", sif.top_out, 16'h1234);
        checkOutput("s2_pop1_valid", sif.pop_valid, 1);
        popWord();
        checkOutput("s2_pop2_top", sif.top_out, 16'h0005);
        checkOutput("s2_pop2_valid", sif.pop_valid, 1);
        checkOutput("s2_empty", sif.empty, 1);
        idleCycle();
        checkOutput("s2_valid_drops", sif.pop_valid, 0);
        checkOutput("s2_top_held", sif.top_out, 16'h0005);

        // Scenario 3: Call pushes the PC; a pop with Call set is still a pop
        applyStimulus(1'b1, 1'b0, 1'b1, 16'hAAAA, 16'h321D, 1'b0);
        sif.peek_off = 4'd0;
        #1;
        checkOutput("s3_peek_pc", sif.peek_data, 16'h321D);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h5555, 16'h7777, 1'b0);
        checkOutput("s3_pop_pc", sif.top_out, 16'h321D);
        checkOutput("s3_sp", sif.sp, 0);

        // Scenario 4: overflow at DEPTH
        for (int i = 0; i < 16; i++) pushWord(16'h1000 + 16'(i));
        checkOutput("s4_sp_full", sif.sp, 16);
        checkOutput("s4_full", sif.full, 1);
        checkOutput("s4_no_overflow_yet", sif.overflow, 0);
        pushWord(16'hDEAD);
        checkOutput("s4_sp_held", sif.sp, 16);
        checkOutput("s4_overflow", sif.overflow, 1);
        sif.peek_off = 4'd0;
        #1;
        checkOutput("s4_entry15", sif.peek_data, 16'h100F);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        checkOutput("s4_overflow_clr", sif.overflow, 0);
        popWord();
        checkOutput("s4_pop_top", sif.top_out, 16'h100F);
        for (int i = 0; i < 15; i++) popWord();
        checkOutput("s4_drain_top", sif.top_out, 16'h1000);
        checkOutput("s4_drain_empty", sif.empty, 1);

        // Scenario 5: underflow, and error beating ClearErr on the same edge
        popWord();
        checkOutput("s5_underflow", sif.underflow, 1);
        checkOutput("s5_sp", sif.sp, 0);
        checkOutput("s5_top_held", sif.top_out, 16'h1000);
        checkOutput("s5_valid", sif.pop_valid, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
        checkOutput("s5_err_wins", sif.underflow, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        checkOutput("s5_underflow_clr", sif.underflow, 0);

        // Scenario 6: peek across the whole stack and past it
        pushWord(16'h00A0);
        pushWord(16'h00B1);
        pushWord(16'h00C2);
        pushWord(16'h00D3);
        peekExp = '{16'h00D3, 16'h00C2, 16'h00B1, 16'h00A0, 16'h0000, 16'h0000};
        for (int off = 0; off < 6; off++) begin
            sif.peek_off = 4'(off);
            #1;
            checkOutput($sformatf("s6_peek%0d", off), sif.peek_data, peekExp[off]);
        end
        checkOutput("s6_sp", sif.sp, 4);
        sif.peek_off = 4'd0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
